// File: rtl/act_mon_pkg.sv
// Shared types and helpers for the act_mon activity monitor.
// Optional build macro ACT_MON_SAT_EN: event counters saturate instead of wrapping.
package act_mon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Increment a width-bit value; with sat set it sticks at all-ones, otherwise it wraps.
  function automatic logic [31:0] inc(input logic [31:0] value, input int width, input logic sat);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (sat && (value == max_v)) return value;
    return (value + 32'd1) & max_v;
  endfunction

endpackage

// File: rtl/act_mon_channel.sv
// One monitored channel: event counter (cleared by snapshot) and saturating idle counter.
// Optional build macro ACT_MON_SAT_EN: event counter saturates instead of wrapping.
module act_mon_channel
  import act_mon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int IDLE_LIMIT = 16,
  localparam int IDLE_W    = $clog2(IDLE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             idle_o
);

`ifdef ACT_MON_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // An event coinciding with the clear belongs to the new window.
    if (clear_i) begin
      cnt_d = valid_i ? CNT_W'(1) : '0;
    end else if (valid_i) begin
      cnt_d = CNT_W'(inc(32'(cnt_q), CNT_W, SAT_EN));
    end

    idle_cnt_d = idle_cnt_q;
    if (valid_i) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_W'(IDLE_LIMIT)) begin
      idle_cnt_d = IDLE_W'(inc(32'(idle_cnt_q), IDLE_W, 1'b1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idle_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign idle_o = (idle_cnt_q == IDLE_W'(IDLE_LIMIT));

endmodule

// File: rtl/act_mon.sv
// Multi-channel activity monitor: snapshots all channels on start_i and streams one report each.
// Optional build macro ACT_MON_SAT_EN: event counters saturate instead of wrapping.
module act_mon
  import act_mon_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int IDLE_LIMIT = 16,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_valid_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              rpt_valid_o,
  input  logic              rpt_ready_i,
  output logic [CH_W-1:0]   rpt_ch_o,
  output logic [CNT_W-1:0]  rpt_count_o,
  output logic              rpt_idle_o
);

  // Report handshake: a report transfers on a cycle where rpt_valid_o and rpt_ready_i
  // are both high; until then rpt_valid_o stays high and all rpt_* fields hold still.

  state_e            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  snap_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  snap_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] snap_idle_q, snap_idle_d;
  logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
  logic              rpt_idle_q, rpt_idle_d;

  logic [CNT_W-1:0]  ch_cnt [NUM_CH];
  logic [NUM_CH-1:0] ch_idle;
  logic              snap_go;
  logic              accept;
  logic              last_idx;
  logic [CH_W-1:0]   idx_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    act_mon_channel #(
      .CNT_W      (CNT_W),
      .IDLE_LIMIT (IDLE_LIMIT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .valid_i (ch_valid_i[g]),
      .clear_i (snap_go),
      .cnt_o   (ch_cnt[g]),
      .idle_o  (ch_idle[g])
    );
  end

  assign snap_go  = (state_q == ST_IDLE) && start_i;
  assign accept   = (state_q == ST_EMIT) && rpt_ready_i;
  assign last_idx = (idx_q == CH_W'(NUM_CH - 1));
  assign idx_nxt  = idx_q + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_EMIT;
      ST_EMIT: if (rpt_ready_i && last_idx) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == ST_EMIT);
    rpt_valid_o = (state_q == ST_EMIT);
  end

  // Channel 0 is loaded straight into the report registers so its report is ready next cycle.
  always_comb begin
    idx_d       = idx_q;
    snap_cnt_d  = snap_cnt_q;
    snap_idle_d = snap_idle_q;
    rpt_count_d = rpt_count_q;
    rpt_idle_d  = rpt_idle_q;
    if (snap_go) begin
      for (int i = 0; i < NUM_CH; i++) snap_cnt_d[i] = ch_cnt[i];
      snap_idle_d = ch_idle;
      idx_d       = '0;
      rpt_count_d = ch_cnt[0];
      rpt_idle_d  = ch_idle[0];
    end else if (accept) begin
      if (last_idx) begin
        idx_d       = '0;
        rpt_count_d = '0;
        rpt_idle_d  = 1'b0;
      end else begin
        idx_d       = idx_nxt;
        rpt_count_d = snap_cnt_q[idx_nxt];
        rpt_idle_d  = snap_idle_q[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      snap_idle_q <= '0;
      rpt_count_q <= '0;
      rpt_idle_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap_cnt_q[i] <= '0;
    end else begin
      idx_q       <= idx_d;
      snap_idle_q <= snap_idle_d;
      rpt_count_q <= rpt_count_d;
      rpt_idle_q  <= rpt_idle_d;
      for (int i = 0; i < NUM_CH; i++) snap_cnt_q[i] <= snap_cnt_d[i];
    end
  end

  assign rpt_ch_o    = idx_q;
  assign rpt_count_o = rpt_count_q;
  assign rpt_idle_o  = rpt_idle_q;

endmodule
